// File: rtl/rd_interlock_ctl_pkg.sv
// Shared opcode/funct constants, forwarding and destination encodings, and the
// pipeline-slot record used by the RD-stage interlock controller.
package rd_interlock_ctl_pkg;

    localparam logic [4:0] REG_R0  = 5'd0;
    localparam logic [4:0] REG_R31 = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LWL     = 6'h22;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_LWR     = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SWL     = 6'h2A;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_SWR     = 6'h2E;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DEST_RT  = 2'd0,
        DEST_RD  = 2'd1,
        DEST_R31 = 2'd2
    } reg_dest_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       writes;
        logic       is_load;
    } stage_rec_t;

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rd_interlock_ctl_timer.sv
// Multiply/divide busy timer: loads the unit latency on issue, counts down to
// zero, and reports when a dependent HI/LO access may proceed.
module rd_muldiv_timer
    import rd_interlock_ctl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_mult,
    input  logic start_div,
    output logic ready,
    output logic md_busy
);

    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

    logic [5:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (start_mult) begin
            count <= MULT_LOAD;
        end else if (start_div) begin
            count <= DIV_LOAD;
        end else if (count != 6'd0) begin
            count <= count - 6'd1;
        end
    end

    // The result lands on the edge where the count reaches zero, so a count of
    // one already lets the dependent instruction issue into that edge.
    assign ready   = (count <= 6'd1);
    assign md_busy = (count != 6'd0);

endmodule

// File: rtl/rd_interlock_ctl.sv
// RD-stage control: instruction decode for the datapath, load-use and mul/div
// interlocks, and registered forwarding selects for the EX operands.
module rd_interlock_ctl
    import rd_interlock_ctl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_valid,
    input  logic [31:0] INS,
    output logic        SignExtend,
    output logic [1:0]  RegDestCtl,
    output logic        stall,
    output logic        bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        md_busy
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign opcode       = INS[31:26];
    assign rs           = INS[25:21];
    assign rt           = INS[20:16];
    assign rd           = INS[15:11];
    assign funct        = INS[5:0];
    assign unused_shamt = ^INS[10:6];

    reg_dest_e  dest_sel;
    logic       sign_ext;
    logic       wr_en;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_mult;
    logic       is_div;
    logic       is_md_op;
    logic       rd_is_load;
    logic [4:0] rd_dest;
    logic       rd_writes;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no decode
        // path can leave one unassigned and infer a latch.
        sign_ext = 1'b0;
        dest_sel = DEST_RT;
        wr_en    = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        is_mult  = 1'b0;
        is_div   = 1'b0;
        is_md_op = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                dest_sel = DEST_RD;
                wr_en    = 1'b1;
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: uses_rs = 1'b0;
                    FN_JR: begin
                        wr_en   = 1'b0;
                        uses_rt = 1'b0;
                    end
                    FN_JALR: uses_rt = 1'b0;
                    FN_SYSCALL, FN_BREAK: begin
                        wr_en   = 1'b0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                    end
                    FN_MFHI, FN_MFLO: begin
                        uses_rs  = 1'b0;
                        uses_rt  = 1'b0;
                        is_md_op = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        wr_en    = 1'b0;
                        uses_rt  = 1'b0;
                        is_md_op = 1'b1;
                    end
                    FN_MULT, FN_MULTU: begin
                        wr_en    = 1'b0;
                        is_mult  = 1'b1;
                        is_md_op = 1'b1;
                    end
                    FN_DIV, FN_DIVU: begin
                        wr_en    = 1'b0;
                        is_div   = 1'b1;
                        is_md_op = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                sign_ext = 1'b1;
                uses_rs  = 1'b1;
            end
            OP_JAL: begin
                dest_sel = DEST_R31;
                wr_en    = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                sign_ext = 1'b1;
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                sign_ext = 1'b1;
                wr_en    = 1'b1;
                uses_rs  = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                wr_en   = 1'b1;
                uses_rs = 1'b1;
            end
            OP_LUI: wr_en = 1'b1;
            default: begin
                if (is_load_op(opcode)) begin
                    sign_ext = 1'b1;
                    wr_en    = 1'b1;
                    uses_rs  = 1'b1;
                end else if (is_store_op(opcode)) begin
                    sign_ext = 1'b1;
                    uses_rs  = 1'b1;
                    uses_rt  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        case (dest_sel)
            DEST_RD:  rd_dest = rd;
            DEST_R31: rd_dest = REG_R31;
            default:  rd_dest = rt;
        endcase
    end

    // A write to r0 is architecturally discarded, so it must never forward or interlock.
    assign rd_writes  = wr_en & (rd_dest != REG_R0);
    assign rd_is_load = is_load_op(opcode);
    assign SignExtend = sign_ext;
    assign RegDestCtl = dest_sel;

    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    stage_rec_t rd_rec;
    logic       md_ready;
    logic       load_use;
    logic       md_stall;
    logic       issue;

    assign rd_rec = '{valid: 1'b1, dest: rd_dest, writes: rd_writes, is_load: rd_is_load};

    assign load_use = rd_valid & ex_rec.valid & ex_rec.is_load & ex_rec.writes &
                      ((uses_rs & (ex_rec.dest == rs)) | (uses_rt & (ex_rec.dest == rt)));
    assign md_stall = rd_valid & is_md_op & ~md_ready;
    assign stall    = load_use | md_stall;
    assign bubble   = stall & rd_valid;
    assign issue    = rd_valid & ~stall;

    // A load in EX cannot forward its data yet; in that case the older MEM result may still apply.
    function automatic fwd_sel_e fwd_pick(input logic [4:0] src,
                                          input stage_rec_t ex,
                                          input stage_rec_t mem);
        if (ex.valid && ex.writes && !ex.is_load && ex.dest == src) begin
            return FWD_EX;
        end else if (mem.valid && mem.writes && mem.dest == src) begin
            return FWD_MEM;
        end
        return FWD_REG;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rec  <= '0;
            mem_rec <= '0;
            fwd_a   <= FWD_REG;
            fwd_b   <= FWD_REG;
        end else begin
            ex_rec  <= issue ? rd_rec : '0;
            mem_rec <= ex_rec;
            fwd_a   <= issue ? fwd_pick(rs, ex_rec, mem_rec) : FWD_REG;
            fwd_b   <= issue ? fwd_pick(rt, ex_rec, mem_rec) : FWD_REG;
        end
    end

    rd_muldiv_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (issue & is_mult),
        .start_div  (issue & is_div),
        .ready      (md_ready),
        .md_busy    (md_busy)
    );

endmodule

// File: tb/tb_rd_interlock_ctl.sv
// Self-checking bench for rd_interlock_ctl: decode table, directed hazard and
// mul/div sequences, async reset, and random instructions against a reference model.
module tb_rd_interlock_ctl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_valid;
    logic [31:0] INS;
    logic        SignExtend;
    logic [1:0]  RegDestCtl;
    logic        stall;
    logic        bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        md_busy;

    rd_interlock_ctl #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_valid   (rd_valid),
        .INS        (INS),
        .SignExtend (SignExtend),
        .RegDestCtl (RegDestCtl),
        .stall      (stall),
        .bubble     (bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction-class rules as set membership.
    typedef struct {
        logic       sx;
        logic [1:0] rdc;
        logic [4:0] dest;
        logic       wr;
        logic       urs;
        logic       urt;
        logic       load;
        logic       md_op;
        logic       mult;
        logic       div;
    } dec_t;

    typedef struct {
        logic       valid;
        logic [4:0] dest;
        logic       writes;
        logic       load;
    } slot_t;

    function automatic dec_t mdec(input logic [31:0] i);
        dec_t d;
        logic [5:0] op;
        logic [5:0] fn;
        logic       special;
        logic       store;
        op      = i[31:26];
        fn      = i[5:0];
        special = (op == 6'h00);
        d.load  = op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        store   = op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
        d.sx    = (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B})
                  || d.load || store;
        d.rdc   = special ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
        d.dest  = special ? i[15:11] : (op == 6'h03) ? 5'd31 : i[20:16];
        if (special)
            d.wr = !(fn inside {6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h0C, 6'h0D});
        else
            d.wr = (op >= 6'h08 && op <= 6'h0F) || d.load || op == 6'h03;
        d.wr    = d.wr && (d.dest != 5'd0);
        if (special) begin
            d.urs = !(fn inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h0C, 6'h0D});
            d.urt = !(fn inside {6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13, 6'h0C, 6'h0D});
        end else begin
            d.urs = (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07})
                    || (op >= 6'h08 && op <= 6'h0E) || d.load || store;
            d.urt = (op inside {6'h04, 6'h05, 6'h06, 6'h07}) || store;
        end
        d.mult  = special && (fn inside {6'h18, 6'h19});
        d.div   = special && (fn inside {6'h1A, 6'h1B});
        d.md_op = special && (fn inside {6'h10, 6'h11, 6'h12, 6'h13}) || d.mult || d.div;
        return d;
    endfunction

    // Model state: the two in-flight slots, forwarding selects, and the absolute
    // cycle at which the mul/div result becomes available.
    slot_t      ex_m;
    slot_t      mem_m;
    logic [1:0] fwd_a_m;
    logic [1:0] fwd_b_m;
    int         cyc;
    int         md_done;

    logic       obs_stall, obs_bubble, obs_sx, obs_md_busy;
    logic [1:0] obs_rdc, obs_fwd_a, obs_fwd_b;

    function automatic logic [1:0] mfwd(input logic [4:0] r);
        if (ex_m.valid && ex_m.writes && !ex_m.load && ex_m.dest == r) return 2'd1;
        if (mem_m.valid && mem_m.writes && mem_m.dest == r)            return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        ex_m    = '{valid: 1'b0, dest: 5'd0, writes: 1'b0, load: 1'b0};
        mem_m   = ex_m;
        fwd_a_m = 2'd0;
        fwd_b_m = 2'd0;
        md_done = 0;
    endtask

    // One pipeline cycle: drive RD, check all outputs mid-cycle, then advance the model.
    task automatic step(input logic rv, input logic [31:0] ins);
        dec_t       d;
        logic       lu, mds, st, iss;
        logic [1:0] fa, fb;
        rd_valid = rv;
        INS      = ins;
        d   = mdec(ins);
        lu  = rv && ex_m.valid && ex_m.load && ex_m.writes &&
              ((d.urs && ex_m.dest == ins[25:21]) || (d.urt && ex_m.dest == ins[20:16]));
        mds = rv && d.md_op && (cyc < md_done - 1);
        st  = lu || mds;
        @(negedge clk);
        obs_stall   = stall;
        obs_bubble  = bubble;
        obs_sx      = SignExtend;
        obs_rdc     = RegDestCtl;
        obs_fwd_a   = fwd_a;
        obs_fwd_b   = fwd_b;
        obs_md_busy = md_busy;
        check("sign_extend", SignExtend, d.sx);
        check("reg_dest_ctl", RegDestCtl, d.rdc);
        check("stall", stall, st);
        check("bubble", bubble, st && rv);
        check("fwd_a", fwd_a, fwd_a_m);
        check("fwd_b", fwd_b, fwd_b_m);
        check("md_busy", md_busy, cyc < md_done);
        iss = rv && !st;
        fa  = iss ? mfwd(ins[25:21]) : 2'd0;
        fb  = iss ? mfwd(ins[20:16]) : 2'd0;
        @(posedge clk);
        mem_m   = ex_m;
        ex_m    = '{valid: iss, dest: iss ? d.dest : 5'd0, writes: iss && d.wr, load: iss && d.load};
        fwd_a_m = fa;
        fwd_b_m = fb;
        if (iss && d.mult) md_done = cyc + 1 + MULT_CYCLES;
        if (iss && d.div)  md_done = cyc + 1 + DIV_CYCLES;
        cyc++;
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle, released away from the clock edge.
    task automatic reset_mid(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_md_busy"}, md_busy, 1'b0);
        check({tag, "_fwd_a"}, fwd_a, 2'd0);
        check({tag, "_fwd_b"}, fwd_b, 2'd0);
        model_reset();
        rd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    localparam logic [5:0] FN_POOL [21] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02,
                                            6'h03, 6'h04, 6'h08, 6'h09, 6'h10, 6'h12, 6'h11,
                                            6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h0C, 6'h0D};
    localparam logic [5:0] OP_POOL [23] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                            6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                                            6'h29, 6'h2B};

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int          kind;
        kind = $urandom_range(0, 7);
        w    = $urandom;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        if (kind <= 3) begin
            w[31:26] = 6'h00;
            w[5:0]   = FN_POOL[$urandom_range(0, 20)];
        end else if (kind <= 6) begin
            w[31:26] = OP_POOL[$urandom_range(0, 22)];
        end
        return w;
    endfunction

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        sx;
        logic [1:0]  rdc;
    } dvec_t;

    dvec_t dtab [14];

    initial begin
        int n_stall;

        dtab[0]  = '{"dec_addiu", enc_i(6'h09, 0, 1, 16'hFFFF), 1'b1, 2'd0};
        dtab[1]  = '{"dec_ori",   enc_i(6'h0D, 0, 1, 16'hFFFF), 1'b0, 2'd0};
        dtab[2]  = '{"dec_jal",   {6'h03, 26'h0000100},        1'b0, 2'd2};
        dtab[3]  = '{"dec_addu",  enc_r(1, 2, 3, 6'h21),       1'b0, 2'd1};
        dtab[4]  = '{"dec_lw",    enc_i(6'h23, 1, 5, 0),       1'b1, 2'd0};
        dtab[5]  = '{"dec_sw",    enc_i(6'h2B, 1, 5, 4),       1'b1, 2'd0};
        dtab[6]  = '{"dec_beq",   enc_i(6'h04, 1, 2, 16'h8000), 1'b1, 2'd0};
        dtab[7]  = '{"dec_lui",   enc_i(6'h0F, 0, 1, 16'h1234), 1'b0, 2'd0};
        dtab[8]  = '{"dec_andi",  enc_i(6'h0C, 2, 3, 16'hFFFF), 1'b0, 2'd0};
        dtab[9]  = '{"dec_xori",  enc_i(6'h0E, 2, 3, 16'h00FF), 1'b0, 2'd0};
        dtab[10] = '{"dec_sltiu", enc_i(6'h0B, 2, 3, 16'hFFFF), 1'b1, 2'd0};
        dtab[11] = '{"dec_regimm", enc_i(6'h01, 1, 1, 16'h0010), 1'b1, 2'd0};
        dtab[12] = '{"dec_j",     {6'h02, 26'h0000040},        1'b0, 2'd0};
        dtab[13] = '{"dec_lbu",   enc_i(6'h24, 4, 6, 16'h0003), 1'b1, 2'd0};

        rst_n    = 1'b0;
        rd_valid = 1'b0;
        INS      = 32'd0;
        cyc      = 0;
        model_reset();
        #12;
        check("rst_stall", stall, 1'b0);
        check("rst_bubble", bubble, 1'b0);
        check("rst_fwd_a", fwd_a, 2'd0);
        check("rst_fwd_b", fwd_b, 2'd0);
        check("rst_md_busy", md_busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            step(1'b0, dtab[i].ins);
            check({dtab[i].name, "_sx"}, obs_sx, dtab[i].sx);
            check({dtab[i].name, "_rdc"}, obs_rdc, dtab[i].rdc);
        end

        // Load-use: one stall, then the consumer takes the load result from MEM/WB.
        step(1'b1, enc_i(6'h23, 1, 5, 0));
        step(1'b1, enc_r(5, 2, 6, 6'h21));
        check("lu_stall", obs_stall, 1'b1);
        check("lu_bubble", obs_bubble, 1'b1);
        step(1'b1, enc_r(5, 2, 6, 6'h21));
        check("lu_release", obs_stall, 1'b0);
        step(1'b0, 32'd0);
        check("lu_fwd_a", obs_fwd_a, 2'd2);
        check("lu_fwd_b", obs_fwd_b, 2'd0);

        step(1'b1, enc_r(1, 2, 4, 6'h21));
        step(1'b1, enc_r(4, 4, 7, 6'h23));
        check("ex_nostall", obs_stall, 1'b0);
        step(1'b0, 32'd0);
        check("ex_fwd_a", obs_fwd_a, 2'd1);
        check("ex_fwd_b", obs_fwd_b, 2'd1);

        step(1'b1, enc_r(1, 2, 0, 6'h21));
        step(1'b1, enc_r(0, 0, 7, 6'h23));
        step(1'b0, 32'd0);
        check("r0_fwd_a", obs_fwd_a, 2'd0);
        check("r0_fwd_b", obs_fwd_b, 2'd0);

        step(1'b1, enc_r(1, 2, 4, 6'h21));
        step(1'b1, enc_r(2, 3, 4, 6'h21));
        step(1'b1, enc_r(4, 0, 8, 6'h25));
        step(1'b0, 32'd0);
        check("prio_fwd_a", obs_fwd_a, 2'd1);
        check("prio_fwd_b", obs_fwd_b, 2'd0);

        // DIV then MFLO: the MFLO waits until the counter is down to one.
        step(1'b1, enc_r(1, 2, 0, 6'h1A));
        n_stall = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, enc_r(0, 0, 3, 6'h12));
            if (!obs_stall) break;
            n_stall++;
        end
        check("div_stall_cycles", n_stall, DIV_CYCLES - 1);
        check("div_busy_at_issue", obs_md_busy, 1'b1);
        step(1'b0, 32'd0);
        check("div_busy_fall", obs_md_busy, 1'b0);

        step(1'b1, enc_r(1, 2, 0, 6'h1A));
        step(1'b1, enc_r(0, 0, 3, 6'h12));
        step(1'b1, enc_r(0, 0, 3, 6'h12));
        check("pre_rst_stall", obs_stall, 1'b1);
        rd_valid = 1'b1;
        INS      = enc_r(0, 0, 3, 6'h12);
        reset_mid("rst_md");
        step(1'b1, enc_r(1, 2, 9, 6'h21));
        check("post_rst_indep", obs_stall, 1'b0);
        step(1'b1, enc_r(0, 0, 3, 6'h12));
        check("post_rst_mflo", obs_stall, 1'b0);

        step(1'b1, enc_r(1, 2, 4, 6'h21));
        step(1'b1, enc_r(4, 4, 7, 6'h23));
        check("pre_rst_fwd_a", fwd_a, 2'd1);
        reset_mid("rst_fwd");

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) < 85, rand_ins());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, required $finish");
        $fatal(1);
    end

endmodule

// File: doc/rd_interlock_ctl.md
Name: rd_interlock_ctl

Overview:
- Control companion to the Read/Decode datapath stage.
- Decodes the RD-stage instruction into the stage's control inputs: SignExtend and the RegDestCtl select (0=rt, 1=rd, 2=r31).
- Tracks the instructions in EX and MEM so it can detect load-use hazards and produce forwarding selects.
- Interlocks the pipeline against a multi-cycle multiply/divide unit.

Parameters:
- MULT_CYCLES, 4, busy cycles after MULT/MULTU issues (1..63)
- DIV_CYCLES, 32, busy cycles after DIV/DIVU issues (1..63)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid  in  1  RD holds a real instruction
- INS  in  32  instruction in RD
- SignExtend  out  1  combinational; to RD stage
- RegDestCtl  out  2  combinational; to RD stage
- stall  out  1  combinational; hold PC and IF/RD register
- bubble  out  1  combinational; EX receives NOP this edge (equals stall & rd_valid)
- fwd_a  out  2  registered; EX operand A source: 0=regfile, 1=EX/MEM result, 2=MEM/WB result
- fwd_b  out  2  registered; same encoding for operand B
- md_busy  out  1  registered; multiply/divide counter nonzero

Behaviour:
- Reset (async assert, sync release): EX/MEM records invalid, counter=0, fwd_a=fwd_b=0, md_busy=0.
- Decode is purely combinational from INS. Fields: opcode[31:26], funct[5:0], rs[25:21], rt[20:16], rd[15:11].
- SignExtend=1 for ADDI, ADDIU, SLTI, SLTIU, all loads/stores, BEQ, BNE, BLEZ, BGTZ, REGIMM. SignExtend=0 for ANDI, ORI, XORI, LUI and all others.
- RegDestCtl:
  - 1 when opcode=0 (SPECIAL)
  - 2 for JAL
  - 0 otherwise
- writes (destination write-back) is set for:
  - SPECIAL, except JR, MULT(U), DIV(U), MTHI, MTLO, SYSCALL, BREAK
  - I-type ALU ops and LUI
  - loads
  - JAL
- writes is forced to 0 when the resolved destination is r0.
- uses_rs/uses_rt decode per opcode/funct. Shifts by sa do not use rs; stores and branches use rt.
- EX record {valid, dest, writes, is_load} loads every cycle:
  - from the RD decode when rd_valid & ~stall
  - else invalid (bubble)
- MEM record <= EX record every cycle.
- Load-use stall: stall when all of the following hold:
  - rd_valid
  - EX.valid, EX.is_load, EX.writes
  - EX.dest matches rs with uses_rs, or rt with uses_rt
- Forwarding (computed in RD, registered into fwd_a/fwd_b on a non-stalled edge, cleared to 0 on a bubble edge):
  - operand = EX.dest, EX.valid & EX.writes, not a load → 1
  - else operand = MEM.dest, MEM.valid & MEM.writes → 2
  - else → 0
  - EX has priority over MEM when both match.
- Mul/div counter (6 bits):
  - MULT(U) issuing (rd_valid & ~stall) loads MULT_CYCLES.
  - DIV(U) issuing loads DIV_CYCLES.
  - Otherwise the counter decrements when nonzero and saturates at 0.
  - md_busy = (counter != 0).
- Mul/div stall: stall when rd_valid, the RD instruction is MFHI, MFLO, MTHI, MTLO, MULT(U) or DIV(U), and the counter is not 0 or 1. The result is ready on the edge at which the counter reaches 0.
- stall = load-use stall | mul/div stall.
- Both stall causes in the same cycle: one stall; it re-evaluates next cycle.
- rd_valid=0: stall=0, EX loads bubble, decode outputs still driven from INS.
- Reset mid-stall: all state clears immediately; stall is low once rst_n deasserts and no hazard exists.

Decomposition:
- mips.h gains opcode/funct constants (OP_SPECIAL, OP_JAL, OP_LW…, FN_MULT, FN_DIV, FN_MFHI…) and the FWD_REG/FWD_EX/FWD_MEM encodings. It already holds the field macros and r31.
- One sub-module: rd_muldiv_timer (counter, load/decrement, md_busy, ready compare).
- Decode and hazard logic stay in the top module.

Test Plan:
- ADDIU r1,r0,0xFFFF → SignExtend=1, RegDestCtl=0. ORI r1,r0,0xFFFF → SignExtend=0. JAL → RegDestCtl=2. ADDU r3,r1,r2 → RegDestCtl=1.
- LW r5,0(r1) then ADDU r6,r5,r2 → stall=1 for exactly one cycle, bubble=1. The ADDU then enters EX with fwd_a=2, fwd_b=0.
- ADDU r4,r1,r2; SUBU r7,r4,r4 → no stall, fwd_a=fwd_b=1. Repeat with the destination r0 → fwd=0.
- ADDU r4,…; ADDU r4,…; OR r8,r4,r0 → fwd_a=1 (EX priority over MEM).
- DIV r1,r2 followed immediately by MFLO r3, DIV_CYCLES=32 → stall held for 31 cycles, MFLO issues when the counter reaches 1, md_busy falls the next edge.
- Assert rst_n=0 during the mul/div stall → stall, md_busy, fwd_a and fwd_b go to 0 asynchronously. After release, an independent instruction issues without stalling.
